alu_share_arbiter: RTL
======================

# alu_share_arbiter

Two-port arbiter and sequencer that shares the single RV32 integer ALU between two requesters, for example the main execute path and an auxiliary branch/address unit. It accepts operation requests over valid/ready handshakes and picks a winner round-robin. It registers the winner's operands and control onto the ALU inputs, captures the ALU outputs one cycle later, and returns them on the winner's response channel. The block sits between the requesters and the combinational ALU; the ALU itself is unchanged.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must match the ALU.
- CTRLW, 4, ALU control width.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- reqN_valid  in  1  (N = 0,1) requester N presents an operation.
- reqN_ready  out  1  block accepts from requester N this cycle.
- reqN_op1, reqN_op2  in  WIDTH  operands.
- reqN_ctrl  in  CTRLW  ALU control code (0000 add, 1000 sub, 0111 and, 0110 or, 0100 xor, 0001 sll, 0101 srl, 1111 sra, 0010 slt, 0011 sltu).
- alu_op1, alu_op2  out  WIDTH  registered ALU operands.
- alu_ctrl  out  CTRLW  registered ALU control.
- alu_result  in  WIDTH  combinational ALU result.
- alu_zero, alu_less  in  1  ALU flags.
- rspN_valid  out  1  response for requester N available.
- rspN_ready  in  1  requester N consumes the response.
- rspN_result  out  WIDTH  captured result.
- rspN_zero, rspN_less  out  1  captured flags.

## Operation
- The FSM has three states: IDLE, EXEC, RESP. Reset state is IDLE.
- **IDLE:**
  - reqN_ready = 1 for both ports. This is a Moore output from state only and never depends on reqN_valid.
  - If any reqN_valid is high, grant one requester:
    - Only one valid: that requester wins.
    - Both valid: the requester selected by priority pointer `prio` wins.
  - On grant:
    - Load alu_op1/op2/ctrl from the winner.
    - Record the winner id in `owner`.
    - Set `prio` to the other requester.
    - Go to EXEC.
  - The loser's request is not accepted; it must hold valid and payload.
- **EXEC:**
  - Both reqN_ready = 0.
  - Capture alu_result/zero/less into the response register for `owner`.
  - Go to RESP.
- **RESP:**
  - Both reqN_ready = 0.
  - rsp[owner]_valid = 1; the other rsp valid = 0.
  - When rsp[owner]_ready is high, the response handshakes. Go to IDLE.
  - Otherwise hold the response; its data stays stable.
- The response data of the non-owner port holds its last captured value; it is don't-care while its valid is low.
- Pass-through rules:
  - Operands and control pass unmodified, with no masking of shift amounts and no code checking.
  - Illegal codes reach the ALU, which returns result 0, zero 1.
- alu_op1/op2/ctrl hold their last granted values outside EXEC. They change only on a grant.
- `prio` changes only on a grant when both requesters were valid or one was valid. It always points to the non-winner after any grant.

## Timing
- **Reset values** (asynchronous on rst_n low):
  - state IDLE, prio 0, owner 0.
  - alu_op1/op2 = 0, alu_ctrl = 0.
  - rspN_valid = 0, rspN_result = 0, rspN_zero = 0, rspN_less = 0.
  - reqN_ready = 1, following from IDLE.
- **Latency:** request accepted at edge T; result registered at edge T+1; rspN_valid high from T+1 until the response handshake.
- **Throughput:** at best one operation every 3 cycles (accept, exec, response handshake). A new grant is possible on the cycle after the response handshake.
- **Response handshake:** a response transfers on a cycle where rspN_valid and rspN_ready are both high. A rspN_ready that is high early, before valid, has no effect.
- **Reset mid-operation** (EXEC or RESP):
  - The pending operation and response are dropped.
  - No response is issued after rst_n is released.
  - Requesters re-present the request.
- **Simultaneous events:**
  - Both valid in IDLE: exactly one grant, per `prio`.
  - A request arriving in EXEC or RESP waits; reqN_ready is already low.

## Test plan
- Reset, then req0 add op1=5, op2=7 → req0 accepted at edge T; rsp0_valid at T+1 with result 12, zero 0, less 0; req1_ready low during EXEC/RESP; alu_op1 = 5.
- After reset, both valid in the same cycle: req0 sub 3−3 and req1 slt 0xFFFFFFFF vs 1 → req0 served first (result 0, zero 1); then req1 (result 1, less 1, zero 0).
- Both requesters continuously valid for 4 ops with rspN_ready tied high → grant order 0,1,0,1; each op spans exactly 3 cycles.
- req1 sra 0x80000000 by 4 with rsp1_ready low for 5 cycles → rsp1_valid held high; result 0xF8000000 stable; both reqN_ready low; no new grant until the handshake.
- rst_n pulsed low during EXEC of a req1 op → immediately rsp valids 0, alu_ctrl 0, prio 0; after release, no stale response; a subsequent simultaneous request grants req0 first.
- req0 with illegal ctrl 4'b1001, op1=9, op2=9 → alu_ctrl 1001 driven; rsp0 result 0, zero 1, less 0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Shares one combinational RV32 ALU between two requesters. Picks a round-robin
// winner, registers its operands onto the ALU, captures the ALU outputs one cycle
// later, and returns them on the winner's response channel.
module alu_share_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CTRLW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  // requester 0
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_op1,
  input  logic [WIDTH-1:0] req0_op2,
  input  logic [CTRLW-1:0] req0_ctrl,
  // requester 1
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_op1,
  input  logic [WIDTH-1:0] req1_op2,
  input  logic [CTRLW-1:0] req1_ctrl,
  // shared ALU
  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  output logic [CTRLW-1:0] alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_less,
  // response 0
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,
  output logic             rsp0_less,
  // response 1
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero,
  output logic             rsp1_less
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state_q;
  logic             prio_q;
  logic             owner_q;
  logic [WIDTH-1:0] alu_op1_q;
  logic [WIDTH-1:0] alu_op2_q;
  logic [CTRLW-1:0] alu_ctrl_q;
  logic [1:0]       rsp_valid_q;
  logic [WIDTH-1:0] rsp0_result_q;
  logic [WIDTH-1:0] rsp1_result_q;
  logic [1:0]       rsp_zero_q;
  logic [1:0]       rsp_less_q;

  logic             any_valid;
  logic             winner;
  logic             rsp_done;
  logic [WIDTH-1:0] win_op1;
  logic [WIDTH-1:0] win_op2;
  logic [CTRLW-1:0] win_ctrl;

  // Round-robin winner select and response handshake for the current owner.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    // Requester 1 wins when it is alone, or when both ask and the pointer favours it.
    winner    = req1_valid & (~req0_valid | prio_q);
    win_op1   = winner ? req1_op1  : req0_op1;
    win_op2   = winner ? req1_op2  : req0_op2;
    win_ctrl  = winner ? req1_ctrl : req0_ctrl;
    rsp_done  = owner_q ? rsp1_ready : rsp0_ready;
  end

  // Sequencer: grant in idle, capture ALU outputs in exec, hold response until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      prio_q        <= 1'b0;
      owner_q       <= 1'b0;
      alu_op1_q     <= '0;
      alu_op2_q     <= '0;
      alu_ctrl_q    <= '0;
      rsp_valid_q   <= '0;
      rsp0_result_q <= '0;
      rsp1_result_q <= '0;
      rsp_zero_q    <= '0;
      rsp_less_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_valid) begin
            alu_op1_q  <= win_op1;
            alu_op2_q  <= win_op2;
            alu_ctrl_q <= win_ctrl;
            owner_q    <= winner;
            prio_q     <= ~winner;
            state_q    <= StExec;
          end
        end
        StExec: begin
          if (owner_q) rsp1_result_q <= alu_result;
          else         rsp0_result_q <= alu_result;
          rsp_zero_q[owner_q]  <= alu_zero;
          rsp_less_q[owner_q]  <= alu_less;
          rsp_valid_q[owner_q] <= 1'b1;
          state_q              <= StResp;
        end
        StResp: begin
          if (rsp_done) begin
            rsp_valid_q <= '0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Ready is a pure function of state: only idle accepts.
  assign req0_ready  = (state_q == StIdle);
  assign req1_ready  = (state_q == StIdle);

  assign alu_op1     = alu_op1_q;
  assign alu_op2     = alu_op2_q;
  assign alu_ctrl    = alu_ctrl_q;

  assign rsp0_valid  = rsp_valid_q[0];
  assign rsp0_result = rsp0_result_q;
  assign rsp0_zero   = rsp_zero_q[0];
  assign rsp0_less   = rsp_less_q[0];
  assign rsp1_valid  = rsp_valid_q[1];
  assign rsp1_result = rsp1_result_q;
  assign rsp1_zero   = rsp_zero_q[1];
  assign rsp1_less   = rsp_less_q[1];

endmodule
